dcache_port_arbiter: RTL and testbench
======================================

# dcache_port_arbiter

Request front-end of the direct-mapped write-back data cache. It accepts the three CPU request ports (PTW, load unit, store unit) and arbitrates between them with fixed priority. It collects the physical tag, which may arrive late, and hands exactly one normalised, fully-qualified request at a time to the cache controller FSM. It also routes the controller's completion and read data back to the originating port.

## Interface
Parameters:
- `NUM_PORTS`, default 3: number of CPU request ports. Index equals `request_port_select_t` (`PTW_PORT`=0, `LOAD_UNIT_PORT`=1, `STORE_UNIT_PORT`=2).

Ports:
- `clk_i`, in, 1: clock. One clock domain.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `req_ports_i`, in, `NUM_PORTS` x `dcache_req_i_t`: CPU requests. Fields used: `address_index`, `address_tag`, `data_wdata`, `data_req`, `data_we`, `data_be`, `data_size`, `kill_req`, `tag_valid`.
- `req_ports_o`, out, `NUM_PORTS` x `dcache_req_o_t`: per-port `data_gnt`, `data_rvalid`, `data_rdata`.
- `ctrl_req_valid_o`, out, 1: normalised request valid to the cache controller.
- `ctrl_req_ready_i`, in, 1: controller accepts the request.
- `ctrl_req_o`, out, `cpu_req_t`: the latched request.
- `ctrl_done_i`, in, 1: single-cycle pulse; the controller has finished the accepted request.
- `ctrl_rdata_i`, in, XLEN: load data, valid with `ctrl_done_i`.
- `busy_o`, out, 1: state is not `ARB_IDLE`.

## Operation
- States:
  - `ARB_IDLE`: waiting for a port request.
  - `ARB_WAIT_TAG`: index latched, waiting for the tag.
  - `ARB_ISSUE`: presenting the request to the controller.
  - `ARB_WAIT_DONE`: waiting for the controller's completion.
- `ARB_IDLE`:
  - Winner is the lowest-index port with `data_req`=1 (PTW > load > store).
  - Drive winner's `data_gnt`=1 combinationally that cycle.
  - Latch index, wdata, we, be, size and port id.
  - If winner's `tag_valid`=1 that cycle, also latch the tag and go to `ARB_ISSUE`; else go to `ARB_WAIT_TAG`.
- `ARB_WAIT_TAG`, watching the latched port only:
  - `kill_req`=1 (it wins over a simultaneous `tag_valid`): pulse that port's `data_rvalid`=1 with `data_rdata`=0 for 1 cycle, then go to `ARB_IDLE`.
  - Otherwise `tag_valid`=1: latch `address_tag` and go to `ARB_ISSUE`.
- `ARB_ISSUE`:
  - `ctrl_req_valid_o`=1 with `ctrl_req_o` stable until `ctrl_req_ready_i`=1.
  - On the handshake, go to `ARB_WAIT_DONE`.
- `ARB_WAIT_DONE`: on `ctrl_done_i`, go to `ARB_IDLE`.
  - Read (`we`=0): pulse `data_rvalid`=1 with `data_rdata`=`ctrl_rdata_i` on the latched port, same cycle.
  - Store: no rvalid.
- `paddr` = {tag, index}, width `riscv::PLEN`. Index is `DCACHE_INDEX_WIDTH` (12) bits; tag is `DCACHE_TAG_WIDTH` bits.
- `size` is zero-extended from the 2-bit CPU size to the 3-bit memory encoding (`CPU_REQUEST_SIZE_*` to `MEMORY_REQUEST_SIZE_*`).
- No `data_gnt` is given in any state except `ARB_IDLE`. Losing or late ports keep `data_req` high and are served later; starvation of lower ports is accepted.
- `kill_req` in `ARB_ISSUE` or `ARB_WAIT_DONE` is ignored. The request is committed and completes normally, including rvalid for loads.
- `ctrl_done_i` outside `ARB_WAIT_DONE` is ignored.
- `kill_req` on a non-latched port is ignored.

## Timing
- Reset (synchronous, `rst_ni`=0 at a clock edge):
  - State goes to `ARB_IDLE`; all latched fields clear to 0.
  - All `data_gnt`/`data_rvalid` are 0; `ctrl_req_valid_o`=0; `busy_o`=0; `data_rdata`=0.
- Reset mid-transaction drops the transaction silently. No rvalid is produced.
- Request to `ctrl_req_valid_o`:
  - 1 cycle when the tag arrives with the request (gnt in cycle N, valid in N+1).
  - Otherwise valid one cycle after `tag_valid`.
- `ctrl_done_i` to `data_rvalid`: 0 cycles (combinational passthrough), gated by state and latched port.
- Next grant is possible in the cycle after `ctrl_done_i` at the earliest. Throughput is at most one request per 3 cycles.

## Structure
- Add to `dcache_pkg`:
  - `cpu_req_t`: packed struct with `paddr`, `wdata`, `we`, `be`, `size[2:0]`, `port` (`request_port_select_t`).
  - `arb_state_t` enum.
  - A `cpu_to_memory_size()` function.
- Priority selection is an inline leading-one search. No sub-module is needed; reuse the common `lzc` if preferred.

## Test plan
- Store, index 0x010, tag 0x00001, `tag_valid` together with `data_req` → `data_gnt`[2] at N; `ctrl_req_o.paddr`=0x00001010, `we`=1 at N+1; no rvalid after done.
- Load, index 0x0A4, tag given 2 cycles after gnt; controller returns `ctrl_rdata_i`=0xDEADBEEF → `data_rvalid`[1]=1, rdata 0xDEADBEEF, same cycle as done.
- PTW and load request in the same cycle → PTW granted first. Load is granted the cycle after PTW's done; no gnt on port 1 before that.
- Load killed in `ARB_WAIT_TAG`, with `kill_req` and `tag_valid` both high → rvalid[1] with data 0; `ctrl_req_valid_o` never asserts.
- `ctrl_req_ready_i` held low 5 cycles → `ctrl_req_o` stable throughout; `kill_req` then asserted is ignored and the load completes with rvalid.
- `rst_ni` low during `ARB_WAIT_DONE` → next cycle `busy_o`=0 and all outputs 0; a subsequent store is granted normally.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter_pkg
//   Shared types and constants for the data-cache request front-end:
//   - CPU port request/response structs (dcache_req_i_t / dcache_req_o_t)
//   - port identifiers (request_port_select_t)
//   - the normalised controller request (cpu_req_t)
//   - the arbiter FSM state encoding (arb_state_t)
//   - cpu_to_memory_size(): 2-bit CPU size -> 3-bit memory size encoding
// -----------------------------------------------------------------------------
package dcache_port_arbiter_pkg;

    localparam int XLEN               = 32;
    localparam int PLEN               = 32;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;

    typedef enum logic [1:0] {
        PTW_PORT        = 2'd0,
        LOAD_UNIT_PORT  = 2'd1,
        STORE_UNIT_PORT = 2'd2
    } request_port_select_t;

    localparam logic [1:0] CPU_REQUEST_SIZE_8     = 2'b00;
    localparam logic [1:0] CPU_REQUEST_SIZE_16    = 2'b01;
    localparam logic [1:0] CPU_REQUEST_SIZE_32    = 2'b10;
    localparam logic [1:0] CPU_REQUEST_SIZE_64    = 2'b11;

    localparam logic [2:0] MEMORY_REQUEST_SIZE_8  = 3'b000;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_16 = 3'b001;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_32 = 3'b010;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_64 = 3'b011;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [PLEN-1:0]      paddr;
        logic [XLEN-1:0]      wdata;
        logic                 we;
        logic [XLEN/8-1:0]    be;
        logic [2:0]           size;
        request_port_select_t port;
    } cpu_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_TAG  = 2'd1,
        ARB_ISSUE     = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic logic [2:0] cpu_to_memory_size(input logic [1:0] cpu_size);
        logic [2:0] mem_size;
        case (cpu_size)
            CPU_REQUEST_SIZE_8:  mem_size = MEMORY_REQUEST_SIZE_8;
            CPU_REQUEST_SIZE_16: mem_size = MEMORY_REQUEST_SIZE_16;
            CPU_REQUEST_SIZE_32: mem_size = MEMORY_REQUEST_SIZE_32;
            default:             mem_size = MEMORY_REQUEST_SIZE_64;
        endcase
        return mem_size;
    endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter_if
//   Bundles the CPU request ports and the cache-controller handshake.
//   Modports:
//     slave  - the arbiter: receives port requests and controller responses,
//              drives grants/rvalid/rdata and the normalised request.
//     master - the environment (CPU ports + cache controller).
//   Handshake rule: ctrl_req_o is transferred on a cycle where
//   ctrl_req_valid_o and ctrl_req_ready_i are both 1; while valid is high
//   and ready is low, ctrl_req_o is held stable. CPU ports keep data_req
//   high until they see data_gnt.
// -----------------------------------------------------------------------------
interface dcache_port_arbiter_if #(
    parameter int NUM_PORTS = 3
);
    import dcache_port_arbiter_pkg::*;

    dcache_req_i_t   req_ports_i [NUM_PORTS];
    dcache_req_o_t   req_ports_o [NUM_PORTS];
    logic            ctrl_req_valid_o;
    logic            ctrl_req_ready_i;
    cpu_req_t        ctrl_req_o;
    logic            ctrl_done_i;
    logic [XLEN-1:0] ctrl_rdata_i;

    modport slave (
        input  req_ports_i,
        output req_ports_o,
        output ctrl_req_valid_o,
        input  ctrl_req_ready_i,
        output ctrl_req_o,
        input  ctrl_done_i,
        input  ctrl_rdata_i
    );

    modport master (
        output req_ports_i,
        input  req_ports_o,
        input  ctrl_req_valid_o,
        output ctrl_req_ready_i,
        input  ctrl_req_o,
        output ctrl_done_i,
        output ctrl_rdata_i
    );

endinterface

// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//   Fixed-priority front-end of the data cache. Grants the lowest-index
//   requesting port, collects a possibly late physical tag, presents one
//   normalised request to the controller and routes completion/read data
//   back to the originating port.
//   Ports:
//     clk_i    - clock
//     rst_ni   - synchronous active-low reset
//     bus      - dcache_port_arbiter_if.slave (CPU ports + controller)
//     busy_o   - 1 whenever the FSM is not in ARB_IDLE
//     state_o  - current FSM state (debug)
// -----------------------------------------------------------------------------
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dcache_port_arbiter_if.slave  bus,
    output logic                  busy_o,
    output arb_state_t            state_o
);

    localparam int PORT_W = 2;

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    cpu_req_t      r_req;

    // Winner of the priority search (valid only when w_found)
    logic                          w_found;
    logic [PORT_W-1:0]             w_winner;
    logic [DCACHE_INDEX_WIDTH-1:0] w_win_index;
    logic [DCACHE_TAG_WIDTH-1:0]   w_win_tag;
    logic [XLEN-1:0]               w_win_wdata;
    logic                          w_win_we;
    logic [XLEN/8-1:0]             w_win_be;
    logic [1:0]                    w_win_size;
    logic                          w_win_tag_valid;

    // Fields of the port latched in r_req.port
    logic                          w_lat_kill;
    logic                          w_lat_tag_valid;
    logic [DCACHE_TAG_WIDTH-1:0]   w_lat_tag;

    dcache_req_o_t w_req_o [NUM_PORTS];

    // Leading-one search: iterating from the highest index down lets the
    // lowest requesting index overwrite the result last, so it wins.
    always_comb begin
        w_found         = 1'b0;
        w_winner        = '0;
        w_win_index     = '0;
        w_win_tag       = '0;
        w_win_wdata     = '0;
        w_win_we        = 1'b0;
        w_win_be        = '0;
        w_win_size      = '0;
        w_win_tag_valid = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req_ports_i[i].data_req) begin
                w_found         = 1'b1;
                w_winner        = PORT_W'(i);
                w_win_index     = bus.req_ports_i[i].address_index;
                w_win_tag       = bus.req_ports_i[i].address_tag;
                w_win_wdata     = bus.req_ports_i[i].data_wdata;
                w_win_we        = bus.req_ports_i[i].data_we;
                w_win_be        = bus.req_ports_i[i].data_be;
                w_win_size      = bus.req_ports_i[i].data_size;
                w_win_tag_valid = bus.req_ports_i[i].tag_valid;
            end
        end
    end

    always_comb begin
        w_lat_kill      = 1'b0;
        w_lat_tag_valid = 1'b0;
        w_lat_tag       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_req.port == PORT_W'(i)) begin
                w_lat_kill      = bus.req_ports_i[i].kill_req;
                w_lat_tag_valid = bus.req_ports_i[i].tag_valid;
                w_lat_tag       = bus.req_ports_i[i].address_tag;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_next_state = w_win_tag_valid ? ARB_ISSUE : ARB_WAIT_TAG;
                end
            end
            ARB_WAIT_TAG: begin
                // A kill beats a tag arriving in the same cycle.
                if (w_lat_kill) begin
                    w_next_state = ARB_IDLE;
                end else if (w_lat_tag_valid) begin
                    w_next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.ctrl_req_ready_i) begin
                    w_next_state = ARB_WAIT_DONE;
                end
            end
            ARB_WAIT_DONE: begin
                if (bus.ctrl_done_i) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // FSM: outputs. Grants only in IDLE; rvalid for a kill in WAIT_TAG or
    // a read completion in WAIT_DONE, always on the latched port only.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_req_o[i] = '0;
            if (r_state == ARB_IDLE && w_found && w_winner == PORT_W'(i)) begin
                w_req_o[i].data_gnt = 1'b1;
            end
            if (r_req.port == PORT_W'(i)) begin
                if (r_state == ARB_WAIT_TAG && w_lat_kill) begin
                    w_req_o[i].data_rvalid = 1'b1;
                end
                if (r_state == ARB_WAIT_DONE && bus.ctrl_done_i && !r_req.we) begin
                    w_req_o[i].data_rvalid = 1'b1;
                    w_req_o[i].data_rdata  = bus.ctrl_rdata_i;
                end
            end
        end
    end

    assign bus.req_ports_o      = w_req_o;
    assign bus.ctrl_req_valid_o = (r_state == ARB_ISSUE);
    assign bus.ctrl_req_o       = r_req;
    assign busy_o               = (r_state != ARB_IDLE);
    assign state_o              = r_state;

    // Request latch. The tag half of paddr is filled either at grant time
    // (tag already valid) or later from the latched port in WAIT_TAG.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_req <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_req.paddr <= {(w_win_tag_valid ? w_win_tag
                                                         : {DCACHE_TAG_WIDTH{1'b0}}),
                                        w_win_index};
                        r_req.wdata <= w_win_wdata;
                        r_req.we    <= w_win_we;
                        r_req.be    <= w_win_be;
                        r_req.size  <= cpu_to_memory_size(w_win_size);
                        r_req.port  <= request_port_select_t'(w_winner);
                    end
                end
                ARB_WAIT_TAG: begin
                    if (!w_lat_kill && w_lat_tag_valid) begin
                        r_req.paddr[PLEN-1:DCACHE_INDEX_WIDTH] <= w_lat_tag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       busy_o;
    arb_state_t state_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    dcache_port_arbiter_if #(.NUM_PORTS(3)) bus ();

    dcache_port_arbiter #(.NUM_PORTS(3)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bus     (bus),
        .busy_o  (busy_o),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [2:0] gnt_vec();
        return {bus.req_ports_o[2].data_gnt, bus.req_ports_o[1].data_gnt,
                bus.req_ports_o[0].data_gnt};
    endfunction

    function automatic logic [2:0] rvalid_vec();
        return {bus.req_ports_o[2].data_rvalid, bus.req_ports_o[1].data_rvalid,
                bus.req_ports_o[0].data_rvalid};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ports();
        for (int i = 0; i < 3; i++) bus.req_ports_i[i] = '0;
    endtask

    task automatic drive_req(input int p, input logic [11:0] idx, input logic [19:0] tag,
                             input logic tv, input logic we, input logic [31:0] wd,
                             input logic [1:0] sz);
        bus.req_ports_i[p].data_req      = 1'b1;
        bus.req_ports_i[p].address_index = idx;
        bus.req_ports_i[p].address_tag   = tag;
        bus.req_ports_i[p].tag_valid     = tv;
        bus.req_ports_i[p].data_we       = we;
        bus.req_ports_i[p].data_wdata    = wd;
        bus.req_ports_i[p].data_be       = 4'hF;
        bus.req_ports_i[p].data_size     = sz;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_ports();
        bus.ctrl_req_ready_i = 1'b0;
        bus.ctrl_done_i      = 1'b0;
        bus.ctrl_rdata_i     = '0;
        rst_ni               = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        settle();
        check("rst_busy",   busy_o, 0);
        check("rst_state",  state_o, ARB_IDLE);
        check("rst_valid",  bus.ctrl_req_valid_o, 0);
        check("rst_gnt",    gnt_vec(), 0);
        check("rst_rvalid", rvalid_vec(), 0);
        check("rst_paddr",  bus.ctrl_req_o.paddr, 0);

        // ctrl_done_i while idle is ignored
        bus.ctrl_done_i  = 1'b1;
        bus.ctrl_rdata_i = 32'h5555_AAAA;
        settle();
        check("idle_done_rvalid", rvalid_vec(), 0);
        check("idle_done_busy",   busy_o, 0);
        step();
        bus.ctrl_done_i = 1'b0;

        // --- store with tag together with request ---
        drive_req(2, 12'h010, 20'h00001, 1'b1, 1'b1, 32'h1234_5678, 2'b10);
        settle();
        check("st_gnt", gnt_vec(), 3'b100);
        step();
        clear_ports();
        settle();
        check("st_valid", bus.ctrl_req_valid_o, 1);
        check("st_paddr", bus.ctrl_req_o.paddr, 32'h0000_1010);
        check("st_we",    bus.ctrl_req_o.we, 1);
        check("st_wdata", bus.ctrl_req_o.wdata, 32'h1234_5678);
        check("st_size",  bus.ctrl_req_o.size, 3'b010);
        check("st_port",  bus.ctrl_req_o.port, 2);
        bus.ctrl_req_ready_i = 1'b1;
        step();
        bus.ctrl_req_ready_i = 1'b0;
        settle();
        check("st_wait_valid", bus.ctrl_req_valid_o, 0);
        check("st_wait_state", state_o, ARB_WAIT_DONE);
        bus.ctrl_done_i  = 1'b1;
        bus.ctrl_rdata_i = 32'hAAAA_AAAA;
        settle();
        check("st_done_no_rvalid", rvalid_vec(), 0);
        step();
        bus.ctrl_done_i = 1'b0;
        settle();
        check("st_end_busy", busy_o, 0);

        // --- load with tag 2 cycles after grant ---
        drive_req(1, 12'h0A4, 20'h00ABC, 1'b0, 1'b0, 32'h0, 2'b00);
        settle();
        check("ld_gnt", gnt_vec(), 3'b010);
        step();
        bus.req_ports_i[1].data_req = 1'b0;
        settle();
        check("ld_wt_state", state_o, ARB_WAIT_TAG);
        check("ld_wt_gnt",   gnt_vec(), 0);
        check("ld_wt_valid", bus.ctrl_req_valid_o, 0);
        step();
        bus.req_ports_i[1].tag_valid = 1'b1;
        step();
        bus.req_ports_i[1].tag_valid = 1'b0;
        settle();
        check("ld_valid", bus.ctrl_req_valid_o, 1);
        check("ld_paddr", bus.ctrl_req_o.paddr, 32'h00AB_C0A4);
        check("ld_we",    bus.ctrl_req_o.we, 0);
        check("ld_size",  bus.ctrl_req_o.size, 3'b000);
        bus.ctrl_req_ready_i = 1'b1;
        step();
        bus.ctrl_req_ready_i = 1'b0;
        bus.ctrl_done_i      = 1'b1;
        bus.ctrl_rdata_i     = 32'hDEAD_BEEF;
        settle();
        check("ld_rvalid", rvalid_vec(), 3'b010);
        check("ld_rdata",  bus.req_ports_o[1].data_rdata, 32'hDEAD_BEEF);
        step();
        bus.ctrl_done_i = 1'b0;
        clear_ports();
        settle();
        check("ld_end_rvalid", rvalid_vec(), 0);
        check("ld_end_busy",   busy_o, 0);

        // --- PTW and load in the same cycle ---
        drive_req(0, 12'h100, 20'h00002, 1'b1, 1'b0, 32'h0, 2'b11);
        drive_req(1, 12'h200, 20'h00003, 1'b1, 1'b0, 32'h0, 2'b01);
        settle();
        check("pri_gnt", gnt_vec(), 3'b001);
        step();
        bus.req_ports_i[0].data_req = 1'b0;
        settle();
        check("pri_issue_gnt", gnt_vec(), 0);
        check("pri_port",      bus.ctrl_req_o.port, 0);
        check("pri_size",      bus.ctrl_req_o.size, 3'b011);
        check("pri_paddr",     bus.ctrl_req_o.paddr, 32'h0000_2100);
        bus.ctrl_req_ready_i = 1'b1;
        step();
        bus.ctrl_req_ready_i = 1'b0;
        settle();
        check("pri_wd_gnt", gnt_vec(), 0);
        bus.ctrl_done_i  = 1'b1;
        bus.ctrl_rdata_i = 32'h1111_2222;
        settle();
        check("pri_rvalid", rvalid_vec(), 3'b001);
        check("pri_rdata",  bus.req_ports_o[0].data_rdata, 32'h1111_2222);
        check("pri_gnt_at_done", gnt_vec(), 0);
        step();
        bus.ctrl_done_i = 1'b0;
        settle();
        check("pri_ld_gnt", gnt_vec(), 3'b010);
        step();
        bus.req_ports_i[1].data_req = 1'b0;
        settle();
        check("pri_ld_port",  bus.ctrl_req_o.port, 1);
        check("pri_ld_paddr", bus.ctrl_req_o.paddr, 32'h0000_3200);
        check("pri_ld_size",  bus.ctrl_req_o.size, 3'b001);
        bus.ctrl_req_ready_i = 1'b1;
        step();
        bus.ctrl_req_ready_i = 1'b0;
        bus.ctrl_done_i      = 1'b1;
        bus.ctrl_rdata_i     = 32'h3333_4444;
        step();
        bus.ctrl_done_i = 1'b0;
        clear_ports();

        // --- load killed in WAIT_TAG with simultaneous tag_valid ---
        drive_req(1, 12'h0F0, 20'h00044, 1'b0, 1'b0, 32'h0, 2'b10);
        step();
        bus.req_ports_i[1].data_req = 1'b0;
        bus.req_ports_i[0].kill_req = 1'b1;  // kill on a non-latched port
        settle();
        check("kill_other_rvalid", rvalid_vec(), 0);
        check("kill_other_state",  state_o, ARB_WAIT_TAG);
        step();
        bus.req_ports_i[0].kill_req  = 1'b0;
        bus.req_ports_i[1].kill_req  = 1'b1;
        bus.req_ports_i[1].tag_valid = 1'b1;
        bus.ctrl_rdata_i             = 32'hFFFF_FFFF;
        settle();
        check("kill_rvalid", rvalid_vec(), 3'b010);
        check("kill_rdata",  bus.req_ports_o[1].data_rdata, 0);
        check("kill_valid",  bus.ctrl_req_valid_o, 0);
        step();
        clear_ports();
        settle();
        check("kill_end_state",  state_o, ARB_IDLE);
        check("kill_end_valid",  bus.ctrl_req_valid_o, 0);
        check("kill_end_rvalid", rvalid_vec(), 0);

        // --- ready held low 5 cycles, late kill ignored ---
        drive_req(1, 12'h3FF, 20'hFFFFF, 1'b1, 1'b0, 32'h0, 2'b10);
        step();
        bus.req_ports_i[1].data_req  = 1'b0;
        bus.req_ports_i[1].tag_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("stall_valid", bus.ctrl_req_valid_o, 1);
            check("stall_paddr", bus.ctrl_req_o.paddr, 32'hFFFF_F3FF);
            step();
        end
        bus.req_ports_i[1].kill_req = 1'b1;
        settle();
        check("late_kill_valid",  bus.ctrl_req_valid_o, 1);
        check("late_kill_rvalid", rvalid_vec(), 0);
        bus.ctrl_req_ready_i = 1'b1;
        step();
        bus.ctrl_req_ready_i = 1'b0;
        settle();
        check("late_kill_wd_rvalid", rvalid_vec(), 0);
        check("late_kill_wd_state",  state_o, ARB_WAIT_DONE);
        bus.ctrl_done_i  = 1'b1;
        bus.ctrl_rdata_i = 32'hCAFE_F00D;
        settle();
        check("late_kill_rvalid_done", rvalid_vec(), 3'b010);
        check("late_kill_rdata",       bus.req_ports_o[1].data_rdata, 32'hCAFE_F00D);
        step();
        bus.ctrl_done_i = 1'b0;
        clear_ports();

        // --- reset during WAIT_DONE ---
        drive_req(2, 12'h555, 20'h12345, 1'b1, 1'b1, 32'h0BAD_F00D, 2'b10);
        step();
        clear_ports();
        bus.ctrl_req_ready_i = 1'b1;
        step();
        bus.ctrl_req_ready_i = 1'b0;
        settle();
        check("mid_rst_pre_state", state_o, ARB_WAIT_DONE);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        settle();
        check("mid_rst_busy",  busy_o, 0);
        check("mid_rst_valid", bus.ctrl_req_valid_o, 0);
        check("mid_rst_gnt",   gnt_vec(), 0);
        check("mid_rst_paddr", bus.ctrl_req_o.paddr, 0);
        bus.ctrl_done_i  = 1'b1;
        bus.ctrl_rdata_i = 32'h7777_7777;
        settle();
        check("mid_rst_done_rvalid", rvalid_vec(), 0);
        step();
        bus.ctrl_done_i = 1'b0;
        drive_req(2, 12'h020, 20'h00009, 1'b1, 1'b1, 32'h0000_00AA, 2'b00);
        settle();
        check("post_rst_gnt", gnt_vec(), 3'b100);
        step();
        clear_ports();
        settle();
        check("post_rst_valid", bus.ctrl_req_valid_o, 1);
        check("post_rst_paddr", bus.ctrl_req_o.paddr, 32'h0000_9020);
        check("post_rst_we",    bus.ctrl_req_o.we, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
